fifo_multi_channel: RTL
=======================

Name: fifo_multi_channel

Overview:
- Parametrised multi-channel FIFO. NCH independent logical queues, each DEPTH entries, share one NCH*DEPTH x WIDTH storage array addressed as {channel, pointer}.
- One push port and one pop port per cycle; each carries a channel select.
- Adds features the single-queue FIFO lacks:
  - registered pop data with a valid strobe;
  - push-into-full when a same-channel pop occurs in the same cycle;
  - per-channel flush;
  - almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags;
  - a memory-clearing init sequence after reset.
- Sits between multi-stream producers and consumers, e.g. per-port queueing.

Parameters:
- NCH, 4, number of logical channels.
- LG_NCH, 2, log2(NCH); NCH must be a power of two.
- DEPTH, 16, entries per channel; power of two.
- LG_DEPTH, 4, log2(DEPTH).
- WIDTH, 10, data width in bits.
- AFULL_TH, 12, afull[c] asserts when count[c] >= AFULL_TH.
- AEMPTY_TH, 2, aempty[c] asserts when count[c] <= AEMPTY_TH.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- ready, out, 1, high when init is complete and requests are accepted.
- pu_en, in, 1, push request.
- pu_ch, in, LG_NCH, push channel.
- pu_data, in, WIDTH, push data.
- po_en, in, 1, pop request.
- po_ch, in, LG_NCH, pop channel.
- po_data, out, WIDTH, registered pop data.
- po_vld, out, 1, po_data is valid this cycle.
- flush_en, in, 1, flush request.
- flush_ch, in, LG_NCH, channel to flush.
- err_clr, in, 1, clears all sticky error flags.
- full, out, NCH, per-channel full (count == DEPTH).
- empty, out, NCH, per-channel empty (count == 0).
- afull, out, NCH, per-channel almost full.
- aempty, out, NCH, per-channel almost empty.
- count_flat, out, NCH*(LG_DEPTH+1), per-channel occupancy; channel c occupies bits [c*(LG_DEPTH+1) +: LG_DEPTH+1].
- err_ovf, out, NCH, sticky: push attempted while the channel could not accept.
- err_udf, out, NCH, sticky: pop attempted on an empty channel.

Behaviour:
- State machine: INIT -> RUN.
  - rst in any cycle forces INIT on the next edge, including mid-operation; all in-flight state is discarded.
  - INIT writes 0 to every storage address, one address per cycle, NCH*DEPTH cycles.
  - After the last write the state becomes RUN and ready rises on the following cycle.
- Values forced by rst: ready=0, po_vld=0, po_data=0, all head/tail/count=0, err_ovf=0, err_udf=0.
  - Hence empty=all ones, full=0, afull=0, aempty=all ones.
- While ready=0, push, pop and flush are ignored and set no error flags.
- Pop accept: po_en && !empty[po_ch] && no flush on po_ch this cycle.
  - Next cycle: po_data = mem[{po_ch, head}], po_vld=1; head advances mod DEPTH.
  - po_vld is high for exactly one cycle per accepted pop.
  - po_data holds its last value when no pop occurs.
- Push accept: pu_en && (!full[pu_ch] || pop accepted on pu_ch this cycle) && no flush on pu_ch.
  - Data is written at {pu_ch, tail}; tail advances mod DEPTH, wrapping DEPTH-1 -> 0.
- Count update per channel:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
  - Push and pop may target different channels in the same cycle; each channel updates independently.
- No bypass: a pop to an empty channel is rejected even if the same cycle pushes that channel.
- Flush: head, tail and count of flush_ch become 0 next cycle.
  - Flush has priority over push and pop to the same channel in the same cycle; those requests are discarded without error.
  - Other channels are unaffected.
- Errors:
  - err_ovf[c] sets when pu_en targets c, push is not accepted, and there is no flush on c.
  - err_udf[c] sets when po_en targets c, c is empty, and there is no flush on c.
  - Flags are sticky until err_clr or rst. If set and err_clr occur in the same cycle, set wins.
- full, empty, afull and aempty are combinational from the count registers. Updated counts are visible the cycle after the event.

Test Plan:
- Init: deassert rst -> ready=0 for NCH*DEPTH cycles (64 at defaults), then 1; all counts 0, empty=4'b1111; every pop returns 0 until data is written.
- Fill ch2 with 0..15 -> full[2]=1, afull[2]=1 once count reaches 12. A 17th push sets err_ovf[2]=1 and count stays 16. Pops return 0..15 in order, each with po_vld one cycle after po_en.
- ch1 full: push 0x3AA and pop ch1 in the same cycle -> count stays 16, no overflow; the popped word is the oldest entry. Later, 0x3AA emerges last.
- Push ch0 and pop ch3 in the same cycle with ch3 count=5 -> ch0 count +1, ch3 count -1. Pop ch3 on empty with a simultaneous push ch3 -> pop rejected, err_udf[3]=1, count[3]=1.
- Flush ch0 with count=7 while pushing ch0 -> count[0]=0 next cycle, no error; ch1 contents intact. A 20-push/20-pop sequence on ch0 afterwards wraps pointers and returns data in order.
- Assert rst mid-stream with counts nonzero and errors set -> next cycle ready=0, po_vld=0, counts 0, errors 0, INIT repeats. err_clr concurrent with a new overflow -> the flag remains 1.

Source files
------------

// File: rtl/fifo_multi_channel_if.sv
// Push/pop/flush bus of the multi-channel FIFO. The slave modport is the FIFO side,
// the master modport is the producer/consumer side.
interface fifo_multi_channel_if #(
   parameter int unsigned NCH      = 4,
   parameter int unsigned LG_NCH   = 2,
   parameter int unsigned LG_DEPTH = 4,
   parameter int unsigned WIDTH    = 10
);
   logic                         ready;
   logic                         pu_en;
   logic [LG_NCH-1:0]            pu_ch;
   logic [WIDTH-1:0]             pu_data;
   logic                         po_en;
   logic [LG_NCH-1:0]            po_ch;
   logic [WIDTH-1:0]             po_data;
   logic                         po_vld;
   logic                         flush_en;
   logic [LG_NCH-1:0]            flush_ch;
   logic                         err_clr;
   logic [NCH-1:0]               full;
   logic [NCH-1:0]               empty;
   logic [NCH-1:0]               afull;
   logic [NCH-1:0]               aempty;
   logic [NCH*(LG_DEPTH+1)-1:0]  count_flat;
   logic [NCH-1:0]               err_ovf;
   logic [NCH-1:0]               err_udf;

   modport master (
      input  ready, po_data, po_vld, full, empty, afull, aempty, count_flat, err_ovf, err_udf,
      output pu_en, pu_ch, pu_data, po_en, po_ch, flush_en, flush_ch, err_clr
   );

   modport slave (
      output ready, po_data, po_vld, full, empty, afull, aempty, count_flat, err_ovf, err_udf,
      input  pu_en, pu_ch, pu_data, po_en, po_ch, flush_en, flush_ch, err_clr
   );
endinterface

// File: rtl/fifo_multi_channel.sv
// NCH independent FIFO queues sharing one storage array addressed as {channel, pointer},
// with flush, thresholds, sticky error flags and a memory-clearing init after reset.
module fifo_multi_channel #(
   parameter int unsigned NCH       = 4,
   parameter int unsigned LG_NCH    = 2,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned LG_DEPTH  = 4,
   parameter int unsigned WIDTH     = 10,
   parameter int unsigned AFULL_TH  = 12,
   parameter int unsigned AEMPTY_TH = 2
) (
   input logic                  clk,
   input logic                  rst,
   fifo_multi_channel_if.slave  io_bus
);
   localparam int unsigned CW = LG_DEPTH + 1;
   localparam int unsigned AW = LG_NCH + LG_DEPTH;

   typedef enum logic {StInit, StRun} state_e;

   state_e              r_state, w_state_nxt;
   logic [AW-1:0]       r_init_addr, w_init_addr_nxt;
   logic [WIDTH-1:0]    r_mem [NCH*DEPTH];
   logic [LG_DEPTH-1:0] r_head [NCH];
   logic [LG_DEPTH-1:0] r_tail [NCH];
   logic [CW-1:0]       r_count [NCH];
   logic [LG_DEPTH-1:0] w_head_nxt [NCH];
   logic [LG_DEPTH-1:0] w_tail_nxt [NCH];
   logic [CW-1:0]       w_count_nxt [NCH];
   logic [NCH-1:0]      r_err_ovf, r_err_udf, w_ovf_set, w_udf_set;
   logic [NCH-1:0]      w_full, w_empty, w_afull, w_aempty;
   logic [NCH*CW-1:0]   w_count_flat;
   logic [WIDTH-1:0]    r_po_data;
   logic                r_po_vld;
   logic                w_ready, w_flush_pu, w_flush_po, w_pop_acc, w_push_acc;

   // FSM: INIT walks every storage address once, then RUN until the next reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StInit;
         r_init_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_addr <= w_init_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_init_addr_nxt = r_init_addr;
      case (r_state)
         StInit: begin
            w_init_addr_nxt = r_init_addr + 1'b1;
            if (r_init_addr == '1) w_state_nxt = StRun;
         end
         StRun:   w_state_nxt = StRun;
         default: w_state_nxt = StInit;
      endcase
   end

   assign w_ready = (r_state == StRun);

   always_comb begin
      w_count_flat = '0;
      for (int c = 0; c < NCH; c++) begin
         w_full[c]   = (r_count[c] == CW'(DEPTH));
         w_empty[c]  = (r_count[c] == '0);
         w_afull[c]  = (r_count[c] >= CW'(AFULL_TH));
         w_aempty[c] = (r_count[c] <= CW'(AEMPTY_TH));
         w_count_flat[c*CW +: CW] = r_count[c];
      end
   end

   // Flush wins over push/pop on the same channel; a full channel may still take a push
   // when the same cycle pops it.
   assign w_flush_pu = io_bus.flush_en && (io_bus.flush_ch == io_bus.pu_ch);
   assign w_flush_po = io_bus.flush_en && (io_bus.flush_ch == io_bus.po_ch);
   assign w_pop_acc  = w_ready && io_bus.po_en && !w_empty[io_bus.po_ch] && !w_flush_po;
   assign w_push_acc = w_ready && io_bus.pu_en && !w_flush_pu &&
                       (!w_full[io_bus.pu_ch] || (w_pop_acc && (io_bus.po_ch == io_bus.pu_ch)));

   always_comb begin
      w_ovf_set = '0;
      w_udf_set = '0;
      if (w_ready && io_bus.pu_en && !w_push_acc && !w_flush_pu) w_ovf_set[io_bus.pu_ch] = 1'b1;
      if (w_ready && io_bus.po_en && w_empty[io_bus.po_ch] && !w_flush_po) begin
         w_udf_set[io_bus.po_ch] = 1'b1;
      end
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         w_head_nxt[c]  = r_head[c];
         w_tail_nxt[c]  = r_tail[c];
         w_count_nxt[c] = r_count[c];
         if (w_ready && io_bus.flush_en && (io_bus.flush_ch == LG_NCH'(c))) begin
            w_head_nxt[c]  = '0;
            w_tail_nxt[c]  = '0;
            w_count_nxt[c] = '0;
         end else begin
            if (w_pop_acc && (io_bus.po_ch == LG_NCH'(c))) w_head_nxt[c] = r_head[c] + 1'b1;
            if (w_push_acc && (io_bus.pu_ch == LG_NCH'(c))) w_tail_nxt[c] = r_tail[c] + 1'b1;
            case ({w_push_acc && (io_bus.pu_ch == LG_NCH'(c)),
                   w_pop_acc && (io_bus.po_ch == LG_NCH'(c))})
               2'b10:   w_count_nxt[c] = r_count[c] + 1'b1;
               2'b01:   w_count_nxt[c] = r_count[c] - 1'b1;
               default: w_count_nxt[c] = r_count[c];
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            r_head[c]  <= '0;
            r_tail[c]  <= '0;
            r_count[c] <= '0;
         end
         r_err_ovf <= '0;
         r_err_udf <= '0;
         r_po_vld  <= 1'b0;
         r_po_data <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            r_head[c]  <= w_head_nxt[c];
            r_tail[c]  <= w_tail_nxt[c];
            r_count[c] <= w_count_nxt[c];
         end
         // A new error in the same cycle as err_clr stays set
         r_err_ovf <= (io_bus.err_clr ? '0 : r_err_ovf) | w_ovf_set;
         r_err_udf <= (io_bus.err_clr ? '0 : r_err_udf) | w_udf_set;
         r_po_vld  <= w_pop_acc;
         if (w_pop_acc) r_po_data <= r_mem[{io_bus.po_ch, r_head[io_bus.po_ch]}];
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == StInit) begin
         r_mem[r_init_addr] <= '0;
      end else if (w_push_acc) begin
         r_mem[{io_bus.pu_ch, r_tail[io_bus.pu_ch]}] <= io_bus.pu_data;
      end
   end

   assign io_bus.ready      = w_ready;
   assign io_bus.po_data    = r_po_data;
   assign io_bus.po_vld     = r_po_vld;
   assign io_bus.full       = w_full;
   assign io_bus.empty      = w_empty;
   assign io_bus.afull      = w_afull;
   assign io_bus.aempty     = w_aempty;
   assign io_bus.count_flat = w_count_flat;
   assign io_bus.err_ovf    = r_err_ovf;
   assign io_bus.err_udf    = r_err_udf;
endmodule
